// File: rtl/odyssey_video_pkg.sv
// Shared types and defaults for the Odyssey raster timing generator.
// Contents:
//   video_timing_t  - the four segment lengths of one raster axis
//   Vt*Default      - stock horizontal, 60 Hz and 50 Hz vertical timings
//   seg_total()     - total length of an axis (active + porches + sync)
package odyssey_video_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } video_timing_t;

  localparam video_timing_t VtHDefault   = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam video_timing_t VtV60Default = '{active: 240, fp: 3,  sync: 3,  bp: 16};
  localparam video_timing_t VtV50Default = '{active: 288, fp: 3,  sync: 3,  bp: 21};

  function automatic int unsigned seg_total(video_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/odyssey_ce_div.sv
// Clock-enable divider: one-cycle enable every CLK_DIV system clocks.
// Ports:
//   clk     - system clock
//   reset   - synchronous, active-high
//   ce_next - enable that ce_pix will present after the next edge; lets a
//             consumer update its registers on the same edge ce_pix rises
//   ce_pix  - registered enable, high for one clk out of every CLK_DIV
module odyssey_ce_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic ce_next,
  output logic ce_pix
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  if (CLK_DIV == 0) begin : g_bad_clk_div
    $fatal(1, "odyssey_ce_div: CLK_DIV must be non-zero");
  end

  logic [DivW-1:0] div_q;
  logic            ce_q;

  assign ce_next = ~reset & (div_q == DivLast);
  assign ce_pix  = ce_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      div_q <= (div_q == DivLast) ? '0 : div_q + 1'b1;
      ce_q  <= ce_next;
    end
  end

endmodule

// File: rtl/odyssey_video_timing.sv
// Parametrised raster timing generator for the Odyssey core.
// Ports:
//   clk, reset             - system clock, synchronous active-high reset
//   mode50                 - 1 selects 50 Hz vertical timing, taken at frame wrap
//   ce_pix                 - pixel clock-enable
//   hsync, vsync           - active-high sync
//   hblank, vblank, de     - blanking (porches + sync) and data-enable
//   hcount, vcount         - beam position
//   new_line, new_frame    - pulse with the ce_pix entering h==0 / (0,0)
//   mode50_act             - vertical mode currently in effect
// All outputs except ce_pix are registered on the edge where ce_pix rises,
// decoded from the next-state counts so they line up with hcount/vcount.
module odyssey_video_timing
  import odyssey_video_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned HW          = 10,
  parameter int unsigned VW          = 10,
  parameter int unsigned H_ACTIVE    = VtHDefault.active,
  parameter int unsigned H_FP        = VtHDefault.fp,
  parameter int unsigned H_SYNC      = VtHDefault.sync,
  parameter int unsigned H_BP        = VtHDefault.bp,
  parameter int unsigned V_ACTIVE    = VtV60Default.active,
  parameter int unsigned V_FP        = VtV60Default.fp,
  parameter int unsigned V_SYNC      = VtV60Default.sync,
  parameter int unsigned V_BP        = VtV60Default.bp,
  parameter int unsigned V_ACTIVE_50 = VtV50Default.active,
  parameter int unsigned V_BP_50     = VtV50Default.bp
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode50,
  output logic          ce_pix,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          new_line,
  output logic          new_frame,
  output logic          mode50_act
);

  localparam video_timing_t HSeg   = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam video_timing_t V60Seg = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam video_timing_t V50Seg = '{active: V_ACTIVE_50, fp: V_FP, sync: V_SYNC, bp: V_BP_50};

  localparam int unsigned HTot   = seg_total(HSeg);
  localparam int unsigned VTot60 = seg_total(V60Seg);
  localparam int unsigned VTot50 = seg_total(V50Seg);

  if (64'(HTot) > (64'd1 << HW)) begin : g_bad_htot
    $fatal(1, "odyssey_video_timing: H total does not fit in HW bits");
  end
  if ((64'(VTot60) > (64'd1 << VW)) || (64'(VTot50) > (64'd1 << VW))) begin : g_bad_vtot
    $fatal(1, "odyssey_video_timing: V total does not fit in VW bits");
  end

  localparam logic [HW-1:0] HLast       = HW'(HTot - 1);
  localparam logic [HW-1:0] HActive     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HSyncStart  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HSyncEnd    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V60Last     = VW'(VTot60 - 1);
  localparam logic [VW-1:0] V60Active   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V60SyncBeg  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V60SyncEnd  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V50Last     = VW'(VTot50 - 1);
  localparam logic [VW-1:0] V50Active   = VW'(V_ACTIVE_50);
  localparam logic [VW-1:0] V50SyncBeg  = VW'(V_ACTIVE_50 + V_FP);
  localparam logic [VW-1:0] V50SyncEnd  = VW'(V_ACTIVE_50 + V_FP + V_SYNC);

  logic ce_next;

  odyssey_ce_div #(
    .CLK_DIV (CLK_DIV)
  ) u_ce_div (
    .clk     (clk),
    .reset   (reset),
    .ce_next (ce_next),
    .ce_pix  (ce_pix)
  );

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          mode50_act_q, mode50_act_d;
  logic          hsync_q, vsync_q, hblank_q, vblank_q, de_q, new_line_q, new_frame_q;
  logic          h_wrap, v_wrap;
  logic [VW-1:0] v_last, v_active, v_sync_beg, v_sync_end;

  always_comb begin
    h_wrap       = (hcount_q == HLast);
    // Frame length follows the mode latched at the previous wrap, so a
    // mid-frame mode50 change cannot stretch or cut the current frame.
    v_last       = mode50_act_q ? V50Last : V60Last;
    v_wrap       = h_wrap && (vcount_q == v_last);
    hcount_d     = h_wrap ? '0 : hcount_q + 1'b1;
    vcount_d     = v_wrap ? '0 : (h_wrap ? vcount_q + 1'b1 : vcount_q);
    mode50_act_d = v_wrap ? mode50 : mode50_act_q;
    // Decode uses the mode that will be in effect alongside vcount_d.
    v_active     = mode50_act_d ? V50Active  : V60Active;
    v_sync_beg   = mode50_act_d ? V50SyncBeg : V60SyncBeg;
    v_sync_end   = mode50_act_d ? V50SyncEnd : V60SyncEnd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q     <= HLast;
      vcount_q     <= mode50 ? V50Last : V60Last;
      mode50_act_q <= mode50;
      hblank_q     <= 1'b1;
      vblank_q     <= 1'b1;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      de_q         <= 1'b0;
      new_line_q   <= 1'b0;
      new_frame_q  <= 1'b0;
    end else if (ce_next) begin
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      mode50_act_q <= mode50_act_d;
      hblank_q     <= (hcount_d >= HActive);
      hsync_q      <= (hcount_d >= HSyncStart) && (hcount_d < HSyncEnd);
      vblank_q     <= (vcount_d >= v_active);
      vsync_q      <= (vcount_d >= v_sync_beg) && (vcount_d < v_sync_end);
      de_q         <= (hcount_d < HActive) && (vcount_d < v_active);
      new_line_q   <= h_wrap;
      new_frame_q  <= v_wrap;
    end
  end

  assign hcount     = hcount_q;
  assign vcount     = vcount_q;
  assign mode50_act = mode50_act_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign hblank     = hblank_q;
  assign vblank     = vblank_q;
  assign de         = de_q;
  assign new_line   = new_line_q;
  assign new_frame  = new_frame_q;

endmodule
